alu_seq: RTL and testbench

//  Parametrised, handshaked successor of the combinational PE ALU. It accepts one operation
//  per transaction on an en/in_ready handshake, computes single-cycle ops into a result

---
 rtl/alu_seq.sv | 160 ++++++++++++++++
 tb/tb_alu_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked sequential ALU with iterative shift-add multiply
// Single-cycle ops register directly; MUL runs MUL_BITS partial products per cycle.
module alu_seq #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_illegal
);

  localparam int HW         = WIDTH / 2;
  localparam int MUL_CYCLES = HW / MUL_BITS;
  localparam int SH_W       = $clog2(WIDTH);
  localparam int CNT_W      = $clog2(MUL_CYCLES) + 1;
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_LTU = 4'b0101;
  localparam logic [3:0] OP_GTU = 4'b0110;
  localparam logic [3:0] OP_EQ  = 4'b0111;
  localparam logic [3:0] OP_OR  = 4'b1000;
  localparam logic [3:0] OP_AND = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;

  typedef enum logic [1:0] {IDLE, MUL, OUT} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [HW-1:0]    mplier;
  logic [CNT_W-1:0] cnt;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_illegal;
  logic [WIDTH:0]   sum;
  logic             big_shamt;
  logic [SH_W-1:0]  shamt;
  logic [WIDTH-1:0] mul_sum;

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    sum         = {1'b0, in1} + {1'b0, in2};
    // The full in2 value is the shift amount; anything >= WIDTH saturates.
    big_shamt   = (in2 >= WIDTH_V);
    shamt       = in2[SH_W-1:0];
    case (instruction)
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = in1 - in2;
        alu_carry = (in1 < in2);
      end
      OP_SLL: alu_res = big_shamt ? '0 : (in1 << shamt);
      OP_SRL: alu_res = big_shamt ? '0 : (in1 >> shamt);
      OP_LTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      OP_GTU: alu_res = {{(WIDTH-1){1'b0}}, (in1 > in2)};
      OP_EQ:  alu_res = {{(WIDTH-1){1'b0}}, (in1 == in2)};
      OP_OR:  alu_res = in1 | in2;
      OP_AND: alu_res = in1 & in2;
      OP_XOR: alu_res = in1 ^ in2;
      OP_SRA: alu_res = big_shamt ? {WIDTH{in1[WIDTH-1]}} : WIDTH'($signed(in1) >>> shamt);
      OP_MUL: alu_res = '0;
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    mul_sum = acc;
    for (int k = 0; k < MUL_BITS; k++) begin
      if (mplier[k]) mul_sum = mul_sum + (mcand << k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out          <= '0;
      flag_zero    <= 1'b0;
      flag_carry   <= 1'b0;
      flag_illegal <= 1'b0;
      cnt          <= '0;
      acc          <= '0;
      mcand        <= '0;
      mplier       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            in_ready <= 1'b0;
            if (instruction == OP_MUL) begin
              mcand  <= {{(WIDTH-HW){1'b0}}, in1[HW-1:0]};
              mplier <= in2[HW-1:0];
              acc    <= '0;
              cnt    <= CNT_W'(MUL_CYCLES - 1);
              state  <= MUL;
            end else begin
              out          <= alu_res;
              flag_zero    <= (alu_res == '0);
              flag_carry   <= alu_carry;
              flag_illegal <= alu_illegal;
              out_valid    <= 1'b1;
              state        <= OUT;
            end
          end
        end
        MUL: begin
          acc    <= mul_sum;
          mcand  <= mcand << MUL_BITS;
          mplier <= mplier >> MUL_BITS;
          if (cnt == '0) begin
            out          <= mul_sum;
            flag_zero    <= (mul_sum == '0);
            flag_carry   <= 1'b0;
            flag_illegal <= 1'b0;
            out_valid    <= 1'b1;
            state        <= OUT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (MUL_BITS=1 and MUL_BITS=4 instances)
module tb_alu_seq;

  typedef struct {
    logic [31:0] out;
    logic        z;
    logic        c;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        en4 = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [3:0]  instruction = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, out_valid, flag_zero, flag_carry, flag_illegal;
  logic [31:0] out;
  logic        in_ready4, out_valid4, flag_zero4, flag_carry4, flag_illegal4;
  logic [31:0] out4;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(32), .MUL_BITS(1)) dut (
    .clk(clk), .rst(rst), .en(en), .in_ready(in_ready), .in1(in1), .in2(in2),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .flag_zero(flag_zero), .flag_carry(flag_carry), .flag_illegal(flag_illegal)
  );

  alu_seq #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .in_ready(in_ready4), .in1(in1), .in2(in2),
    .instruction(instruction), .out_valid(out_valid4), .out_ready(out_ready), .out(out4),
    .flag_zero(flag_zero4), .flag_carry(flag_carry4), .flag_illegal(flag_illegal4)
  );

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] wide;
    e.out = '0; e.c = 1'b0; e.ill = 1'b0;
    case (op)
      4'd0: begin wide = {32'd0, a} + {32'd0, b}; e.out = wide[31:0]; e.c = wide[32]; end
      4'd1: begin e.out = a - b; e.c = (a < b); end
      4'd2: e.out = {16'd0, a[15:0]} * {16'd0, b[15:0]};
      4'd3: e.out = (b > 31) ? 32'd0 : (a << b);
      4'd4: e.out = (b > 31) ? 32'd0 : (a >> b);
      4'd5: e.out = (a < b) ? 32'd1 : 32'd0;
      4'd6: e.out = (a > b) ? 32'd1 : 32'd0;
      4'd7: e.out = (a == b) ? 32'd1 : 32'd0;
      4'd8: e.out = a | b;
      4'd9: e.out = a & b;
      4'd10: e.out = a ^ b;
      4'd11: begin
        wide  = {{32{a[31]}}, a};
        e.out = (b > 31) ? wide[63:32] : 32'(wide >> b);
      end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.out == 32'd0);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    in1 = a; in2 = b; instruction = op; en = 1'b1;
    sbq.push_back(model(op, a, b));
    tick();
    en = 1'b0;
  endtask

  // Returns the cycle (relative to acceptance cycle N) out_valid appeared, or -1.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) n = -1;
  endtask

  task automatic test_reset();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    tests++; if ({out, flag_zero, flag_carry, flag_illegal} !== 35'd0) begin
      fails++; $display("FAIL reset_out_flags got=%h/%b%b%b exp=0", out, flag_zero, flag_carry, flag_illegal); end
  endtask

  task automatic test_add();
    int n; exp_t e;
    send(4'd0, 32'hFFFF_FFFF, 32'h0000_0001);
    wait_valid(n);
    tests++; if (n !== 1) begin fails++; $display("FAIL add_latency got=%0d exp=1", n); end
    e = sbq.pop_front();
    tests++; if ({out, flag_zero, flag_carry, flag_illegal} !== {e.out, e.z, e.c, e.ill} || out !== 32'd0 || flag_carry !== 1'b1) begin
      fails++; $display("FAIL add_wrap got=%h z%b c%b exp=%h z%b c%b", out, flag_zero, flag_carry, e.out, e.z, e.c); end
    tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL add_drain in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
  endtask

  task automatic test_mul();
    int n; exp_t e;
    send(4'd2, 32'h0000_FFFF, 32'h0000_FFFF);
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL mul_busy in_ready=%b out_valid=%b exp 0/0", in_ready, out_valid); end
    in1 = 32'hDEAD_BEEF; in2 = 32'h1234_5678; instruction = 4'd0;
    wait_valid(n);
    tests++; if (n !== 17) begin fails++; $display("FAIL mul_latency got=%0d exp=17", n); end
    e = sbq.pop_front();
    tests++; if (out !== e.out || out !== 32'hFFFE_0001 || flag_zero !== 1'b0 || flag_carry !== 1'b0) begin
      fails++; $display("FAIL mul_ffff got=%h exp=%h", out, e.out); end
    tick();
    send(4'd2, 32'hABCD_1234, 32'h9876_ABCD);
    wait_valid(n);
    e = sbq.pop_front();
    tests++; if (n !== 17 || out !== e.out) begin
      fails++; $display("FAIL mul_upper_ignored got=%h lat=%0d exp=%h lat=17", out, n, e.out); end
    tick();
  endtask

  task automatic test_mul4();
    int n; exp_t e;
    in1 = 32'h0000_FFFF; in2 = 32'h0000_FFFF; instruction = 4'd2; en4 = 1'b1;
    sbq.push_back(model(4'd2, in1, in2));
    tick();
    en4 = 1'b0;
    n = 1;
    while (!out_valid4 && n < 100) begin tick(); n++; end
    e = sbq.pop_front();
    tests++; if (!out_valid4 || n !== 5) begin fails++; $display("FAIL mul4_latency got=%0d exp=5", n); end
    tests++; if (out4 !== e.out || out4 !== 32'hFFFE_0001) begin
      fails++; $display("FAIL mul4_value got=%h exp=%h", out4, e.out); end
    tick();
    tests++; if (in_ready4 !== 1'b1) begin fails++; $display("FAIL mul4_drain in_ready=%b exp=1", in_ready4); end
  endtask

  task automatic test_stall();
    int n; exp_t e;
    out_ready = 1'b0;
    send(4'd1, 32'd3, 32'd5);
    wait_valid(n);
    e = sbq.pop_front();
    for (int i = 0; i < 5; i++) begin
      en = i[0]; in1 = 32'd7; in2 = 32'd9; instruction = 4'd0;
      tests++; if (n !== 1 || out_valid !== 1'b1 || in_ready !== 1'b0 || out !== e.out || out !== 32'hFFFF_FFFE || flag_carry !== 1'b1) begin
        fails++; $display("FAIL stall_hold cyc=%0d out=%h c=%b v=%b rdy=%b exp=%h c=1 v=1 rdy=0", i, out, flag_carry, out_valid, in_ready, e.out); end
      tick();
    end
    en = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++; $display("FAIL stall_release in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid); end
    tick();
    tests++; if (out_valid !== 1'b0 || out !== 32'hFFFF_FFFE) begin
      fails++; $display("FAIL stall_no_queue out_valid=%b out=%h exp 0/fffffffe", out_valid, out); end
  endtask

  task automatic test_shifts();
    logic [3:0]  ops [4]  = '{4'd11, 4'd3, 4'd11, 4'd4};
    logic [31:0] as  [4]  = '{32'h8000_0000, 32'd1, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [4]  = '{32'd4, 32'd32, 32'd40, 32'd31};
    logic [31:0] rs  [4]  = '{32'hF800_0000, 32'd0, 32'hFFFF_FFFF, 32'd1};
    int n; exp_t e;
    for (int i = 0; i < 4; i++) begin
      send(ops[i], as[i], bs[i]);
      wait_valid(n);
      e = sbq.pop_front();
      tests++; if (n !== 1 || out !== rs[i] || out !== e.out || flag_zero !== (rs[i] == 0)) begin
        fails++; $display("FAIL shift_%0d got=%h z=%b lat=%0d exp=%h", i, out, flag_zero, n, rs[i]); end
      tick();
    end
  endtask

  task automatic test_mul_reset();
    int n; exp_t e;
    send(4'd2, 32'h0000_1234, 32'h0000_5678);
    e = sbq.pop_front();
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 32'd0 || {flag_zero, flag_carry, flag_illegal} !== 3'b000) begin
      fails++; $display("FAIL mul_reset rdy=%b v=%b out=%h flags=%b%b%b exp 1/0/0/000", in_ready, out_valid, out, flag_zero, flag_carry, flag_illegal); end
    send(4'd0, 32'd2, 32'd2);
    wait_valid(n);
    e = sbq.pop_front();
    tests++; if (n !== 1 || out !== 32'd4 || out !== e.out) begin
      fails++; $display("FAIL post_reset_add got=%h lat=%0d exp=4 lat=1", out, n); end
    tick();
  endtask

  task automatic test_illegal();
    int n; exp_t e;
    send(4'd15, 32'h1234, 32'h1234);
    wait_valid(n);
    e = sbq.pop_front();
    tests++; if (n !== 1 || out !== 32'd0 || {flag_zero, flag_carry, flag_illegal} !== 3'b101 || flag_illegal !== e.ill) begin
      fails++; $display("FAIL illegal got=%h flags=%b%b%b lat=%0d exp=0 flags=101 lat=1", out, flag_zero, flag_carry, flag_illegal, n); end
    tick();
    send(4'd8, 32'h1, 32'h2);
    wait_valid(n);
    e = sbq.pop_front();
    tests++; if (flag_illegal !== 1'b0 || out !== e.out || out !== 32'h3) begin
      fails++; $display("FAIL illegal_clear ill=%b out=%h exp ill=0 out=3", flag_illegal, out); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n; exp_t e;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 4'(i % 16);
      a  = $urandom;
      b  = (i % 3 == 0) ? a : ((i % 3 == 1) ? 32'($urandom_range(0, 40)) : $urandom);
      send(op, a, b);
      wait_valid(n);
      e = sbq.pop_front();
      tests++; if (n !== ((op == 4'd2) ? 17 : 1) || {out, flag_zero, flag_carry, flag_illegal} !== {e.out, e.z, e.c, e.ill}) begin
        fails++; $display("FAIL b2b_op%0d a=%h b=%h got=%h %b%b%b lat=%0d exp=%h %b%b%b", op, a, b, out, flag_zero, flag_carry, flag_illegal, n, e.out, e.z, e.c, e.ill); end
      tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    rst = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_mul4();
    test_stall();
    test_shifts();
    test_mul_reset();
    test_illegal();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
